// File: rtl/mem_register_table_v2_if.sv
// Command strobe and serialized byte stream between the SPI command buffer
// and the register table.
interface mem_register_table_v2_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 18
);
  logic [ADDR_W-1:0] reg_addr;
  logic [DATA_W-1:0] reg_data;
  logic              reg_input_valid;
  logic [7:0]        byte_out;
  logic              byte_out_valid;
  logic              byte_out_ready;

  modport master (
    output reg_addr, reg_data, reg_input_valid, byte_out_ready,
    input  byte_out, byte_out_valid
  );

  modport slave (
    input  reg_addr, reg_data, reg_input_valid, byte_out_ready,
    output byte_out, byte_out_valid
  );
endinterface

// File: rtl/mem_register_table_v2.sv
// SPI-side register table: decodes register writes into command pulses and
// streams multi-byte readback values LSB-first under valid/ready.
module mem_register_table_v2 #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 18,
  parameter int IDX_W       = 12,
  parameter int STOP_BIT    = 17,
  parameter int NUM_IMG_W   = 12,
  parameter int JPG_SIZE_W  = 24,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                  sysClk,
  input  logic                  rst,
  mem_register_table_v2_if.slave bus,
  input  logic [NUM_IMG_W-1:0]  num_both_img,
  input  logic                  num_both_img_valid,
  input  logic [JPG_SIZE_W-1:0] jpg_size,
  input  logic                  jpg_size_valid,
  input  logic                  done_reading_img_flag,
  input  logic                  done_erasing_img_flag,
  output logic                  read_num_img,
  output logic                  read_img_size,
  output logic [IDX_W-1:0]      img_index,
  output logic                  start_reading_img_flag,
  output logic                  stop_reading_img_flag,
  output logic                  start_erasing_img_flag,
  output logic                  reset_img_pointer_flag,
  output logic                  busy,
  output logic                  cmd_reject
);

  localparam int MAX_W = (NUM_IMG_W > JPG_SIZE_W) ? NUM_IMG_W : JPG_SIZE_W;
  localparam int VAL_W = ((MAX_W + 7) / 8) * 8;
  localparam int NB_W  = $clog2(VAL_W / 8 + 1);
  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [NB_W-1:0]  NB_NUM   = NB_W'((NUM_IMG_W + 7) / 8);
  localparam logic [NB_W-1:0]  NB_JPG   = NB_W'((JPG_SIZE_W + 7) / 8);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_SEND} state_t;

  state_t            state_reg, state_next;
  logic              sel_size_reg, sel_size_next;
  logic              status_reg, status_next;
  logic [VAL_W-1:0]  val_reg, val_next;
  logic [NB_W-1:0]   cnt_reg, cnt_next;
  logic [TMR_W-1:0]  tmr_reg, tmr_next;
  logic              rd_busy_reg, rd_busy_next;
  logic              er_busy_reg, er_busy_next;
  logic              err_timeout_reg, err_timeout_next;
  logic              err_badaddr_reg, err_badaddr_next;
  logic [IDX_W-1:0]  img_index_reg, img_index_next;
  logic              start_rd_reg, start_rd_next;
  logic              stop_rd_reg, stop_rd_next;
  logic              start_er_reg, start_er_next;
  logic              rst_ptr_reg, rst_ptr_next;
  logic              reject_reg, reject_next;

  logic [ADDR_W-1:0] addr_w;
  logic [DATA_W-1:0] data_w;
  logic              any_busy;
  logic              unused_bits;

  assign addr_w      = bus.reg_addr;
  assign data_w      = bus.reg_data;
  assign unused_bits = ^{addr_w, data_w};

  always_ff @(posedge sysClk) begin
    if (rst) begin
      state_reg       <= S_IDLE;
      sel_size_reg    <= 1'b0;
      status_reg      <= 1'b0;
      val_reg         <= '0;
      cnt_reg         <= '0;
      tmr_reg         <= '0;
      rd_busy_reg     <= 1'b0;
      er_busy_reg     <= 1'b0;
      err_timeout_reg <= 1'b0;
      err_badaddr_reg <= 1'b0;
      img_index_reg   <= '0;
      start_rd_reg    <= 1'b0;
      stop_rd_reg     <= 1'b0;
      start_er_reg    <= 1'b0;
      rst_ptr_reg     <= 1'b0;
      reject_reg      <= 1'b0;
    end else begin
      state_reg       <= state_next;
      sel_size_reg    <= sel_size_next;
      status_reg      <= status_next;
      val_reg         <= val_next;
      cnt_reg         <= cnt_next;
      tmr_reg         <= tmr_next;
      rd_busy_reg     <= rd_busy_next;
      er_busy_reg     <= er_busy_next;
      err_timeout_reg <= err_timeout_next;
      err_badaddr_reg <= err_badaddr_next;
      img_index_reg   <= img_index_next;
      start_rd_reg    <= start_rd_next;
      stop_rd_reg     <= stop_rd_next;
      start_er_reg    <= start_er_next;
      rst_ptr_reg     <= rst_ptr_next;
      reject_reg      <= reject_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    sel_size_next    = sel_size_reg;
    status_next      = status_reg;
    val_next         = val_reg;
    cnt_next         = cnt_reg;
    tmr_next         = tmr_reg;
    err_timeout_next = err_timeout_reg;
    err_badaddr_next = err_badaddr_reg;
    img_index_next   = img_index_reg;
    start_rd_next    = 1'b0;
    stop_rd_next     = 1'b0;
    start_er_next    = 1'b0;
    rst_ptr_next     = 1'b0;
    reject_next      = 1'b0;
    // Done pulses land before the acceptance check of a same-cycle command.
    rd_busy_next     = rd_busy_reg & ~done_reading_img_flag;
    er_busy_next     = er_busy_reg & ~done_erasing_img_flag;
    any_busy         = rd_busy_next | er_busy_next;

    case (state_reg)
      S_IDLE: begin
        if (bus.reg_input_valid) begin
          case (addr_w[3:0])
            4'h7: begin
              if (!data_w[STOP_BIT]) begin
                if (!any_busy) begin
                  img_index_next = data_w[IDX_W-1:0];
                  start_rd_next  = 1'b1;
                  rd_busy_next   = 1'b1;
                end else begin
                  reject_next = 1'b1;
                end
              end else if (rd_busy_next) begin
                stop_rd_next = 1'b1;
              end else begin
                reject_next = 1'b1;
              end
            end
            4'hA: begin
              if (!any_busy) begin
                img_index_next = data_w[IDX_W-1:0];
                start_er_next  = 1'b1;
                er_busy_next   = 1'b1;
              end else begin
                reject_next = 1'b1;
              end
            end
            4'hC: begin
              if (any_busy) reject_next = 1'b1;
              else          rst_ptr_next = 1'b1;
            end
            4'h8, 4'h9: begin
              state_next    = S_REQ;
              sel_size_next = addr_w[0];
              status_next   = 1'b0;
              tmr_next      = '0;
            end
            4'hB: begin
              state_next  = S_SEND;
              status_next = 1'b1;
              cnt_next    = NB_W'(1);
              val_next    = VAL_W'({4'b0, err_badaddr_reg, err_timeout_reg,
                                    er_busy_next, rd_busy_next});
            end
            default: begin
              err_badaddr_next = 1'b1;
              reject_next      = 1'b1;
            end
          endcase
        end
      end
      S_REQ: begin
        reject_next = bus.reg_input_valid;
        cnt_next    = sel_size_reg ? NB_JPG : NB_NUM;
        if (sel_size_reg ? jpg_size_valid : num_both_img_valid) begin
          val_next   = sel_size_reg ? VAL_W'(jpg_size) : VAL_W'(num_both_img);
          state_next = S_SEND;
        end else if (tmr_reg == TMR_LAST) begin
          val_next         = sel_size_reg ? VAL_W'({JPG_SIZE_W{1'b1}})
                                          : VAL_W'({NUM_IMG_W{1'b1}});
          err_timeout_next = 1'b1;
          state_next       = S_SEND;
        end else begin
          tmr_next = tmr_reg + TMR_W'(1);
        end
      end
      S_SEND: begin
        reject_next = bus.reg_input_valid;
        if (bus.byte_out_ready) begin
          val_next = val_reg >> 8;
          if (cnt_reg == NB_W'(1)) begin
            state_next = S_IDLE;
            // Error flags are read-to-clear via the status byte.
            if (status_reg) begin
              err_timeout_next = 1'b0;
              err_badaddr_next = 1'b0;
            end
          end else begin
            cnt_next = cnt_reg - NB_W'(1);
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign read_num_img           = (state_reg == S_REQ) && !sel_size_reg;
  assign read_img_size          = (state_reg == S_REQ) && sel_size_reg;
  assign img_index              = img_index_reg;
  assign start_reading_img_flag = start_rd_reg;
  assign stop_reading_img_flag  = stop_rd_reg;
  assign start_erasing_img_flag = start_er_reg;
  assign reset_img_pointer_flag = rst_ptr_reg;
  assign cmd_reject             = reject_reg;
  assign busy                   = (state_reg != S_IDLE) | rd_busy_reg | er_busy_reg;
  assign bus.byte_out           = val_reg[7:0];
  assign bus.byte_out_valid     = (state_reg == S_SEND);

endmodule

// File: doc/mem_register_table_v2.md
Name: mem_register_table_v2

Overview:
- Parametrised successor of the SPI-side register table; sits between the SPI command buffer and the memory interface / image-count blocks.
- Decodes register writes into single-cycle command pulses (read image, stop, erase, reset pointer).
- Fetches multi-byte values (image count, JPEG size, status) and streams them LSB-first to the SPI interface under a valid/ready handshake.
- Adds busy tracking, command rejection, a request timeout and a sticky status register.

Parameters:
- ADDR_W, 8: reg_addr width; only bits [3:0] are decoded.
- DATA_W, 18: reg_data width.
- IDX_W, 12: image index width, taken from reg_data[IDX_W-1:0].
- STOP_BIT, 17: reg_data bit selecting stop (1) vs start (0) on READ_IMG.
- NUM_IMG_W, 12: num_both_img width.
- JPG_SIZE_W, 24: jpg_size width.
- TIMEOUT_CYC, 255: maximum cycles to wait for a *_valid response; must be at least 1.

Ports:
- sysClk, in, 1: system clock.
- rst, in, 1: synchronous reset, active-high.
- reg_addr, in, ADDR_W: register address.
- reg_data, in, DATA_W: register write data.
- reg_input_valid, in, 1: one-cycle command strobe.
- num_both_img, in, NUM_IMG_W: image count.
- num_both_img_valid, in, 1: image count valid.
- jpg_size, in, JPG_SIZE_W: JPEG size.
- jpg_size_valid, in, 1: JPEG size valid.
- done_reading_img_flag, in, 1: image read finished (pulse).
- done_erasing_img_flag, in, 1: erase finished (pulse).
- read_num_img, out, 1: image-count request, level.
- read_img_size, out, 1: JPEG-size request, level.
- img_index, out, IDX_W: latched image index.
- start_reading_img_flag, out, 1: pulse.
- stop_reading_img_flag, out, 1: pulse.
- start_erasing_img_flag, out, 1: pulse.
- reset_img_pointer_flag, out, 1: pulse.
- byte_out, out, 8: serialized byte.
- byte_out_valid, out, 1: byte_out valid.
- byte_out_ready, in, 1: SPI side accepts byte.
- busy, out, 1: readback FSM not idle, or an image read/erase is in progress.
- cmd_reject, out, 1: one-cycle pulse when a command is dropped.

Behaviour:
- Reset: all outputs 0; FSM enters IDLE; rd_busy, er_busy, err_timeout, err_badaddr all cleared.
- Decode of reg_addr[3:0] when reg_input_valid is high and the FSM is in IDLE:
  - 0x7 READ_IMG, reg_data[STOP_BIT]=0: if neither rd_busy nor er_busy is set, latch img_index from reg_data, pulse start_reading_img_flag and set rd_busy; otherwise reject.
  - 0x7 READ_IMG, reg_data[STOP_BIT]=1: if rd_busy, pulse stop_reading_img_flag (rd_busy stays set until the done pulse); otherwise reject.
  - 0xA ERASE_IMG: if neither busy flag is set, latch img_index, pulse start_erasing_img_flag and set er_busy; otherwise reject.
  - 0xC RST_PTR: pulse reset_img_pointer_flag; rejected if rd_busy or er_busy.
  - 0x8 NUM_IMG: go to REQ; width W=NUM_IMG_W.
  - 0x9 IMG_SIZE: go to REQ; width W=JPG_SIZE_W.
  - 0xB STATUS: go to SEND with 1 byte = {4'b0, err_badaddr, err_timeout, er_busy, rd_busy}; err flags clear when this byte is accepted.
  - Any other address: set err_badaddr and pulse cmd_reject.
- Any reg_input_valid while the FSM is not IDLE: pulse cmd_reject; FSM state is unchanged.
- All pulses are registered, one cycle long, and occur on the cycle after the strobe.
- done_reading_img_flag clears rd_busy; done_erasing_img_flag clears er_busy. A done pulse on the same cycle as a new command is applied before the acceptance check.
- FSM states: IDLE -> REQ -> SEND -> IDLE.
- REQ:
  - The matching request level (read_num_img or read_img_size) is asserted from the first REQ cycle until valid is seen.
  - The value is captured on the cycle its valid is high; valid is ignored outside REQ.
  - If TIMEOUT_CYC cycles pass without valid, the value becomes all ones and err_timeout is set.
  - The request level drops when the FSM leaves REQ.
- SEND:
  - NB = (W+7)/8 bytes, byte 0 = bits [7:0] first; the top byte is zero-extended.
  - byte_out_valid stays high while in SEND; byte_out is stable until byte_out_valid && byte_out_ready.
  - The counter advances on each accepted byte; after byte NB-1 is accepted, valid drops in the same edge and the FSM returns to IDLE.
  - There is no gap cycle between consecutive bytes.
- Reset mid-SEND or mid-REQ: the FSM aborts to IDLE and no further bytes are emitted.

Test Plan:
- rst high 2 cycles -> all outputs 0, busy=0; STATUS read returns 0x00.
- NUM_IMG with num_both_img=0xABC, valid 3 cycles after the request, byte_out_ready held high -> read_num_img high 3 cycles; bytes 0xBC then 0x0A on consecutive cycles; then IDLE.
- IMG_SIZE with jpg_size=0x123456, ready toggled 1/0 -> bytes 0x56, 0x34, 0x12, each held stable across not-ready cycles.
- READ_IMG data=0x00005 -> start pulse, img_index=5. A second READ_IMG -> cmd_reject. Stop (bit17=1) -> stop pulse. done_reading_img_flag -> ERASE accepted.
- IMG_SIZE with no jpg_size_valid, TIMEOUT_CYC=4 -> bytes FF, FF, FF. STATUS then returns 0x04; a second STATUS returns 0x00.
- Address 0x3 -> cmd_reject, STATUS bit3=1. rst asserted mid-SEND after byte 0 -> byte_out_valid=0 next cycle, FSM in IDLE.
